// File: rtl/ir_key_ctrl.sv
// NEC IR key command controller: frame check, digit-entry edit buffer, committed BCD value.
// Optional macro IR_KEY_REPEAT_EN lets repeat codes re-execute the last digit/BACK key.
module ir_key_ctrl #(
  parameter logic [7:0]  CUSTOM_CODE = 8'h00,
  parameter logic [31:0] P_TIMEOUT   = 32'd250_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_vld,
  input  logic [31:0] i_frame,
  input  logic        i_repeat,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_cmd_vld,
  output logic [7:0]  o_cmd,
  output logic        o_err,
  output logic [1:0]  o_state
);

  localparam logic [7:0] KeyOk    = 8'h40;
  localparam logic [7:0] KeyBack  = 8'h44;
  localparam logic [7:0] KeyClear = 8'h43;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StEdit = 2'b01
  } state_e;

  // Returns {is_digit, digit value}
  function automatic logic [4:0] dig_decode(input logic [7:0] code);
    case (code)
      8'h16:   dig_decode = {1'b1, 4'd0};
      8'h0C:   dig_decode = {1'b1, 4'd1};
      8'h18:   dig_decode = {1'b1, 4'd2};
      8'h5E:   dig_decode = {1'b1, 4'd3};
      8'h08:   dig_decode = {1'b1, 4'd4};
      8'h1C:   dig_decode = {1'b1, 4'd5};
      8'h5A:   dig_decode = {1'b1, 4'd6};
      8'h42:   dig_decode = {1'b1, 4'd7};
      8'h52:   dig_decode = {1'b1, 4'd8};
      8'h4A:   dig_decode = {1'b1, 4'd9};
      default: dig_decode = 5'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [23:0] ebuf_q, ebuf_d;
  logic [23:0] com_q, com_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic        err_q, err_d;

  logic        frame_ok;
  logic        accept;
  logic        rep_go;
  logic        act;
  logic [7:0]  key;
  logic [4:0]  dig;

`ifdef IR_KEY_REPEAT_EN
  logic [7:0]  last_q, last_d;
  logic        last_vld_q, last_vld_d;
`endif

  always_comb begin
    frame_ok = (i_frame[31:24] == CUSTOM_CODE) && (i_frame[23:16] == ~i_frame[31:24]) &&
               (i_frame[7:0] == ~i_frame[15:8]);
    accept   = i_frame_vld & frame_ok;
`ifdef IR_KEY_REPEAT_EN
    rep_go   = i_repeat & ~i_frame_vld & last_vld_q;
    key      = i_frame_vld ? i_frame[15:8] : last_q;
`else
    rep_go   = 1'b0 & i_repeat;
    key      = i_frame[15:8];
`endif
    act      = accept | rep_go;
    dig      = dig_decode(key);
  end

  always_comb begin
    state_d   = state_q;
    ebuf_d    = ebuf_q;
    com_d     = com_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    cmd_vld_d = 1'b0;
    err_d     = 1'b0;
`ifdef IR_KEY_REPEAT_EN
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (accept) begin
      last_d     = key;
      last_vld_d = dig[4] | (key == KeyBack);
    end else if (i_frame_vld) begin
      last_vld_d = 1'b0;
    end
`endif
    if (act) begin
      cmd_vld_d = 1'b1;
      tmo_d     = '0;
      if (accept) cmd_d = key;
      if (state_q == StIdle) begin
        if (dig[4]) begin
          ebuf_d  = {20'h0, dig[3:0]};
          cnt_d   = 3'd1;
          state_d = StEdit;
        end else if (key == KeyClear) begin
          com_d = '0;
        end
      end else if (dig[4]) begin
        if (cnt_q < 3'd6) begin
          ebuf_d = {ebuf_q[19:0], dig[3:0]};
          cnt_d  = cnt_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (key == KeyBack) begin
        if (cnt_q > 3'd1) begin
          ebuf_d = {4'h0, ebuf_q[23:4]};
          cnt_d  = cnt_q - 3'd1;
        end else begin
          // Backspacing past the last digit cancels the edit
          ebuf_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end else if (key == KeyClear) begin
        ebuf_d = '0;
        cnt_d  = '0;
      end else if (key == KeyOk) begin
        com_d   = ebuf_q;
        ebuf_d  = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    end else begin
      if (i_frame_vld) err_d = 1'b1;
      if (state_q == StEdit) begin
        if (tmo_q == P_TIMEOUT - 32'd1) begin
          ebuf_d  = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ebuf_q    <= '0;
      com_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ebuf_q    <= ebuf_d;
      com_q     <= com_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      err_q     <= err_d;
    end
  end

`ifdef IR_KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

  always_comb begin
    o_digits  = (state_q == StEdit) ? ebuf_q : com_q;
    o_dp      = (state_q == StEdit) ? 6'b000001 : 6'b000000;
    o_state   = state_q;
    o_cmd_vld = cmd_vld_q;
    o_cmd     = cmd_q;
    o_err     = err_q;
  end

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Testbench for ir_key_ctrl: directed scenarios plus random frames against a queue-based model.
module tb_ir_key_ctrl;

  localparam logic [7:0]  CUST = 8'h00;
  localparam int          PTO  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_vld = 1'b0;
  logic [31:0] i_frame = '0;
  logic        i_repeat = 1'b0;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_cmd_vld;
  logic [7:0]  o_cmd;
  logic        o_err;
  logic [1:0]  o_state;

  int checks = 0;
  int failures = 0;

  ir_key_ctrl #(
    .CUSTOM_CODE(CUST),
    .P_TIMEOUT  (32'(PTO))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_frame_vld(i_frame_vld),
    .i_frame    (i_frame),
    .i_repeat   (i_repeat),
    .o_digits   (o_digits),
    .o_dp       (o_dp),
    .o_cmd_vld  (o_cmd_vld),
    .o_cmd      (o_cmd),
    .o_err      (o_err),
    .o_state    (o_state)
  );

  always #10 clk = ~clk;

  logic [7:0] codes [10] = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08, 8'h1C, 8'h5A, 8'h42, 8'h52, 8'h4A};

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] code);
    return {CUST, ~CUST, code, ~code};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: digits held as a queue, leftmost first
  int         m_q[$];
  bit         m_edit;
  logic [23:0] m_com;
  int         m_idle;
  logic [7:0] m_cmd;
  bit         m_cmd_vld, m_err;
  int         m_last;

  function automatic logic [23:0] pack(input int q[$]);
    logic [23:0] v = '0;
    foreach (q[i]) v = {v[19:0], 4'(q[i])};
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_edit = 0; m_com = '0; m_idle = 0; m_cmd = '0;
      m_cmd_vld = 0; m_err = 0; m_last = -1;
    end else begin
      bit go;
      logic [7:0] key;
      int d;
      go = 0; key = '0;
      m_cmd_vld = 0; m_err = 0;
      if (i_frame_vld) begin
        if (i_frame[31:24] == CUST && i_frame[23:16] == ~CUST && i_frame[7:0] == ~i_frame[15:8])
        begin
          go = 1; key = i_frame[15:8]; m_cmd = key; m_last = int'(key);
        end else begin
          m_err = 1; m_last = -1;
        end
      end
`ifdef IR_KEY_REPEAT_EN
      else if (i_repeat && m_last >= 0 &&
               (digit_of(8'(m_last)) >= 0 || m_last == 'h44)) begin
        go = 1; key = 8'(m_last);
      end
`endif
      if (go) begin
        m_cmd_vld = 1; m_idle = 0;
        d = digit_of(key);
        if (!m_edit) begin
          if (d >= 0) begin m_q.delete(); m_q.push_back(d); m_edit = 1; end
          else if (key == 8'h43) m_com = '0;
        end else if (d >= 0) begin
          if (m_q.size() < 6) m_q.push_back(d);
          else m_err = 1;
        end else if (key == 8'h44) begin
          if (m_q.size() > 1) void'(m_q.pop_back());
          else begin m_q.delete(); m_edit = 0; end
        end else if (key == 8'h43) m_q.delete();
        else if (key == 8'h40) begin m_com = pack(m_q); m_q.delete(); m_edit = 0; end
      end else if (m_edit) begin
        m_idle++;
        if (m_idle == PTO) begin m_edit = 0; m_q.delete(); m_idle = 0; end
      end
    end
  end

  always @(negedge clk) begin
    chk("digits", 32'(o_digits), 32'(m_edit ? pack(m_q) : m_com));
    chk("dp", 32'(o_dp), m_edit ? 32'd1 : 32'd0);
    chk("state", 32'(o_state), m_edit ? 32'd1 : 32'd0);
    chk("cmd_vld", 32'(o_cmd_vld), 32'(m_cmd_vld));
    chk("err", 32'(o_err), 32'(m_err));
    chk("cmd", 32'(o_cmd), 32'(m_cmd));
  end

  task automatic send(input logic [31:0] f);
    i_frame_vld = 1'b1;
    i_frame = f;
    @(negedge clk);
    i_frame_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_frame();
    int s;
    logic [31:0] f;
    s = $urandom_range(0, 17);
    if (s < 10) f = mk(codes[s]);
    else if (s == 10) f = mk(8'h40);
    else if (s < 14) f = mk(8'h44);
    else if (s == 14) f = mk(8'h43);
    else f = mk(8'($urandom_range(0, 255)));
    if ($urandom_range(0, 7) == 0) f = f ^ (32'd1 << $urandom_range(0, 31));
    return f;
  endfunction

  initial begin
    int pulses;
    int rate;
    idle(3);
    chk("rst_digits", 32'(o_digits), 32'h0);
    chk("rst_state", 32'(o_state), 32'h0);
    chk("rst_cmd", 32'(o_cmd), 32'h0);
    rst_n = 1'b1;
    idle(2);

    send(32'h00FF0CF3);
    chk("first_cmd_vld", 32'(o_cmd_vld), 32'h1);
    chk("first_cmd", 32'(o_cmd), 32'h0C);
    chk("first_state", 32'(o_state), 32'h1);
    chk("first_digits", 32'(o_digits), 32'h000001);
    chk("first_dp", 32'(o_dp), 32'h1);
    for (int k = 2; k <= 6; k++) send(mk(codes[k]));
    send(mk(codes[7]));
    chk("full_err", 32'(o_err), 32'h1);
    chk("full_digits", 32'(o_digits), 32'h123456);
    send(mk(8'h40));
    chk("ok_state", 32'(o_state), 32'h0);
    chk("ok_digits", 32'(o_digits), 32'h123456);
    chk("ok_dp", 32'(o_dp), 32'h0);

    send(32'h00FF0CF2);
    chk("badcmp_err", 32'(o_err), 32'h1);
    chk("badcmp_vld", 32'(o_cmd_vld), 32'h0);
    send(32'h01FE0CF3);
    chk("badcus_err", 32'(o_err), 32'h1);
    chk("badcus_digits", 32'(o_digits), 32'h123456);

    send(mk(codes[1]));
    send(mk(codes[2]));
    chk("edit12", 32'(o_digits), 32'h000012);
    send(mk(8'h44));
    chk("back1", 32'(o_digits), 32'h000001);
    send(mk(8'h44));
    chk("cancel_state", 32'(o_state), 32'h0);
    chk("cancel_digits", 32'(o_digits), 32'h123456);

    send(mk(codes[5]));
    idle(PTO - 1);
    chk("tmo_before", 32'(o_state), 32'h1);
    idle(1);
    chk("tmo_state", 32'(o_state), 32'h0);
    chk("tmo_digits", 32'(o_digits), 32'h123456);
    send(mk(codes[5]));
    idle(PTO - 2);
    send(mk(codes[3]));
    idle(PTO - 1);
    chk("tmo_restart_edit", 32'(o_state), 32'h1);
    chk("tmo_restart_digits", 32'(o_digits), 32'h000053);
    idle(1);
    chk("tmo_restart_idle", 32'(o_state), 32'h0);

    pulses = 0;
    send(mk(codes[9]));
    if (o_cmd_vld) pulses++;
    repeat (3) begin
      i_repeat = 1'b1;
      @(negedge clk);
      i_repeat = 1'b0;
      if (o_cmd_vld) pulses++;
      idle(1);
    end
`ifdef IR_KEY_REPEAT_EN
    chk("rep_digits", 32'(o_digits), 32'h009999);
    chk("rep_pulses", 32'(pulses), 32'd4);
`else
    chk("rep_digits", 32'(o_digits), 32'h000009);
    chk("rep_pulses", 32'(pulses), 32'd1);
`endif
    send(mk(8'h40));

    send(mk(codes[4]));
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_digits", 32'(o_digits), 32'h0);
    chk("midrst_state", 32'(o_state), 32'h0);
    rst_n = 1'b1;
    idle(2);

    for (int c = 0; c < 4000; c++) begin
      rate = (c < 2000) ? 12 : 2;
      i_frame_vld = 1'b0;
      i_repeat = 1'b0;
      if ($urandom_range(0, 99) < rate) begin
        i_frame_vld = 1'b1;
        i_frame = rand_frame();
      end
      if ($urandom_range(0, 99) < rate / 2 + 1) i_repeat = 1'b1;
      @(negedge clk);
    end
    i_frame_vld = 1'b0;
    i_repeat = 1'b0;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
